// File: rtl/multi_cycle_control_fsm_pkg.sv
// Shared RV32I control definitions: opcode values, ALU op codes, datapath mux selects and sequencer states.
package rv32i_pkg;

    localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
    localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
    localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
    localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
    localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
    localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
    localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
    localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
    localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    typedef enum logic [2:0] {
        RFWD_ALU   = 3'b000,
        RFWD_LOAD  = 3'b001,
        RFWD_LUI   = 3'b010,
        RFWD_AUIPC = 3'b011,
        RFWD_PC4   = 3'b100
    } rfwd_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_RS1   = 2'b10
    } pc_sel_e;

    typedef enum logic [3:0] {
        FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
        S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
    } state_e;

endpackage

// File: rtl/multi_cycle_control_fsm_alu_op_decode.sv
// Combinational ALU operation decode from the instruction word.
module alu_op_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] instrCode,
    output logic [3:0]  aluControl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] rOp;
    logic       unusedBits;

    assign opcode     = instrCode[6:0];
    assign funct3     = instrCode[14:12];
    assign rOp        = {instrCode[30], funct3};
    assign unusedBits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    // For I-type, bit 30 is immediate data except when it selects SRAI.
    always_comb begin
        aluControl = ALU_ADD;
        case (opcode)
            OP_TYPE_R: aluControl = rOp;
            OP_TYPE_I: aluControl = (rOp == ALU_SRA) ? rOp : {1'b0, funct3};
            OP_TYPE_B: aluControl = {1'b0, funct3};
            default:   aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle RV32I sequencer: steps each instruction through its states and drives datapath controls,
// with a timed req/ack handshake to data memory.
module multi_cycle_control_fsm
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        btaken,
    input  logic        dataAck,
    output logic        irEn,
    output logic        pcEn,
    output logic [1:0]  pcSrcSel,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        dataReq,
    output logic        dataWe,
    output logic        illegalInstr,
    output logic        busErr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e     state, nextState;
    logic [CNT_W-1:0] waitCnt;
    pc_sel_e    pcSel;
    rfwd_sel_e  rfwdSel;
    logic [3:0] decodedAlu;
    logic       aluActive;
    logic       memState;
    logic       timeoutHit;
    logic       setIllegal;
    logic       setBusErr;

    alu_op_decode aluDecode (
        .instrCode (instrCode),
        .aluControl(decodedAlu)
    );

    assign memState   = (state == S_MEM) || (state == L_MEM);
    assign timeoutHit = memState && !dataAck && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            waitCnt      <= '0;
            illegalInstr <= 1'b0;
            busErr       <= 1'b0;
        end else begin
            state <= nextState;
            if (state == S_EXE || state == L_EXE)
                waitCnt <= '0;
            else if (memState && !dataAck)
                waitCnt <= waitCnt + CNT_W'(1);
            if (setIllegal)
                illegalInstr <= 1'b1;
            if (setBusErr)
                busErr <= 1'b1;
        end
    end

    always_comb begin
        nextState    = state;
        irEn         = 1'b0;
        pcEn         = 1'b0;
        pcSel        = PC_PLUS4;
        regFileWe    = 1'b0;
        rfwdSel      = RFWD_ALU;
        aluSrcMuxSel = 1'b0;
        dataReq      = 1'b0;
        dataWe       = 1'b0;
        aluActive    = 1'b1;
        setIllegal   = 1'b0;
        setBusErr    = 1'b0;
        case (state)
            FETCH: begin
                irEn      = 1'b1;
                aluActive = 1'b0;
                nextState = DECODE;
            end
            DECODE: begin
                case (instrCode[6:0])
                    OP_TYPE_R:  nextState = R_EXE;
                    OP_TYPE_I:  nextState = I_EXE;
                    OP_TYPE_B:  nextState = B_EXE;
                    OP_TYPE_LU: nextState = LU_EXE;
                    OP_TYPE_AU: nextState = AU_EXE;
                    OP_TYPE_J:  nextState = J_EXE;
                    OP_TYPE_JL: nextState = JL_EXE;
                    OP_TYPE_S:  nextState = S_EXE;
                    OP_TYPE_L:  nextState = L_EXE;
                    default: begin
                        setIllegal = 1'b1;
                        nextState  = TRAP;
                    end
                endcase
            end
            R_EXE, I_EXE, LU_EXE, AU_EXE: begin
                regFileWe    = 1'b1;
                pcEn         = 1'b1;
                aluSrcMuxSel = (state != R_EXE);
                if (state == LU_EXE) rfwdSel = RFWD_LUI;
                if (state == AU_EXE) rfwdSel = RFWD_AUIPC;
                nextState    = FETCH;
            end
            B_EXE: begin
                pcEn      = 1'b1;
                pcSel     = btaken ? PC_IMM : PC_PLUS4;
                nextState = FETCH;
            end
            J_EXE, JL_EXE: begin
                regFileWe    = 1'b1;
                rfwdSel      = RFWD_PC4;
                pcEn         = 1'b1;
                pcSel        = (state == J_EXE) ? PC_IMM : PC_RS1;
                aluSrcMuxSel = (state == JL_EXE);
                nextState    = FETCH;
            end
            S_EXE, L_EXE: begin
                aluSrcMuxSel = 1'b1;
                nextState    = (state == S_EXE) ? S_MEM : L_MEM;
            end
            // A store has no write-back state, so its PC update rides on the ack cycle itself.
            S_MEM, L_MEM: begin
                aluSrcMuxSel = 1'b1;
                dataReq      = 1'b1;
                dataWe       = (state == S_MEM);
                if (dataAck) begin
                    pcEn      = (state == S_MEM);
                    nextState = (state == S_MEM) ? FETCH : L_WB;
                end else if (timeoutHit) begin
                    setBusErr = 1'b1;
                    nextState = TRAP;
                end
            end
            L_WB: begin
                aluSrcMuxSel = 1'b1;
                regFileWe    = 1'b1;
                rfwdSel      = RFWD_LOAD;
                pcEn         = 1'b1;
                nextState    = FETCH;
            end
            TRAP: begin
                aluActive = 1'b0;
            end
            default: begin
                aluActive = 1'b0;
                nextState = FETCH;
            end
        endcase
        // Reset silences every strobe in the same cycle so nothing half-finished reaches memory or the regfile.
        if (reset) begin
            irEn         = 1'b0;
            pcEn         = 1'b0;
            pcSel        = PC_PLUS4;
            regFileWe    = 1'b0;
            rfwdSel      = RFWD_ALU;
            aluSrcMuxSel = 1'b0;
            dataReq      = 1'b0;
            dataWe       = 1'b0;
            aluActive    = 1'b0;
        end
    end

    assign pcSrcSel      = pcSel;
    assign RFWDSrcMuxSel = rfwdSel;
    assign aluControl    = aluActive ? decodedAlu : ALU_ADD;

endmodule
